// File: rtl/controlador_de_rodada_pkg.sv
// Shared definitions for the round controller of the rhythm game.
// Contents: FSM state enum, command constants, button count, settle offset and
// a helper that tells whether a command expects a button press.
package controlador_de_rodada_pkg;

  typedef enum logic [1:0] {
    StOcioso,
    StContagem,
    StJogando,
    StFim
  } estado_e;

  // Explicit rest command; reserved codes 4..14 are treated the same way.
  localparam logic [3:0] CMD_PAUSA = 4'hF;
  localparam int unsigned NUM_BOTOES = 4;
  // Beat cycle at which the pattern manager output is trusted after a step pulse.
  localparam int unsigned ASSENTAMENTO = 2;

  // Commands 0..3 name a button; everything else is a rest beat.
  function automatic logic eh_botao(input logic [3:0] cmd);
    return (cmd[3:2] == 2'b00);
  endfunction

endpackage

// File: rtl/temporizador_de_batida.sv
// Beat timebase: counts 0..CiclosPorBatida-1 while enabled and wraps; held at 0
// while disabled.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           count enable (counter forced to 0 when low)
//   contador_o     current position inside the beat
//   inicio_o       high while the counter is 0
//   fim_o          high while the counter is at its last value
module temporizador_de_batida #(
  parameter int unsigned CiclosPorBatida = 25_000_000,
  localparam int unsigned LargCont = $clog2(CiclosPorBatida)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  output logic [LargCont-1:0] contador_o,
  output logic                inicio_o,
  output logic                fim_o
);

  localparam logic [LargCont-1:0] Ultimo = LargCont'(CiclosPorBatida - 1);

  logic [LargCont-1:0] contador_q, contador_d;

  always_comb begin
    contador_d = '0;
    if (en_i && (contador_q != Ultimo)) begin
      contador_d = contador_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      contador_q <= '0;
    end else begin
      contador_q <= contador_d;
    end
  end

  // Not gated by en_i so the owner's next-state logic can use them without a loop.
  assign contador_o = contador_q;
  assign inicio_o   = (contador_q == '0);
  assign fim_o      = (contador_q == Ultimo);

endmodule

// File: rtl/controlador_de_rodada.sv
// Round controller: beat timebase, step pulses to the pattern manager, judging
// of button presses and hit/miss scoring, end-of-game detection.
// Optional macro CONTROLADOR_SEQUENCIA_EN enables longest-streak tracking on
// sequencia_max; without it sequencia_max is tied to 0.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   iniciar            start request (acts in OCIOSO/FIM)
//   botoes             synchronized active-high player buttons
//   prox_comando       current command from the pattern manager
//   fim_de_jogo        end-of-pattern flag from the pattern manager
//   trocar_comando     one-cycle step pulse to the pattern manager
//   batida             one-cycle pulse at each beat start
//   acertos, erros     saturating hit / miss counters
//   jogando            high during lead-in and play
//   resultado_valido   high once the round has finished
//   sequencia_max      longest hit streak
module controlador_de_rodada
  import controlador_de_rodada_pkg::*;
#(
  parameter int unsigned CICLOS_POR_BATIDA = 25_000_000,
  parameter int unsigned JANELA            = 5_000_000,
  parameter int unsigned BATIDAS_INICIAIS  = 3,
  parameter int unsigned LARGURA_PONTOS    = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      iniciar,
  input  logic [NUM_BOTOES-1:0]     botoes,
  input  logic [3:0]                prox_comando,
  input  logic                      fim_de_jogo,
  output logic                      trocar_comando,
  output logic                      batida,
  output logic [LARGURA_PONTOS-1:0] acertos,
  output logic [LARGURA_PONTOS-1:0] erros,
  output logic                      jogando,
  output logic                      resultado_valido,
  output logic [LARGURA_PONTOS-1:0] sequencia_max
);

  localparam int unsigned LargCont = $clog2(CICLOS_POR_BATIDA);
  localparam logic [LargCont-1:0] CntAssent = LargCont'(ASSENTAMENTO);
  localparam logic [LargCont-1:0] CntJanela = LargCont'(JANELA);
  localparam logic [3:0]          LeadUlt   = 4'(BATIDAS_INICIAIS - 1);

  estado_e                 estado_q, estado_d;
  logic [3:0]              batidas_q, batidas_d;
  logic [NUM_BOTOES-1:0]   botoes_q;
  logic [3:0]              cmd_q, cmd_d;
  logic                    pressionado_q, pressionado_d;
  logic                    acerto_q, acerto_d;
  logic                    trocar_q, trocar_d;
  logic [LARGURA_PONTOS-1:0] acertos_q, acertos_d, erros_q, erros_d;

  logic [LargCont-1:0] contador;
  logic                inicio, fim_batida, en_timer;
  logic                ativo_q, ativo_d;
  logic [3:0]          cmd_atual;
  logic                press, press_acerto, pressionou, acertou;
  logic                limpa, conta_acerto, conta_erro;

  temporizador_de_batida #(
    .CiclosPorBatida(CICLOS_POR_BATIDA)
  ) u_temporizador (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .en_i      (en_timer),
    .contador_o(contador),
    .inicio_o  (inicio),
    .fim_o     (fim_batida)
  );

  assign ativo_q  = (estado_q == StContagem) || (estado_q == StJogando);
  assign ativo_d  = (estado_d == StContagem) || (estado_d == StJogando);
  // Dropping enable on the exit cycle keeps the counter at 0 throughout FIM.
  assign en_timer = ativo_q && ativo_d;

  // At the settle cycle the capture register is being loaded, so judge against the live input.
  assign cmd_atual    = (contador == CntAssent) ? prox_comando : cmd_q;
  assign press        = ((botoes & ~botoes_q) != '0) && (contador >= CntAssent);
  assign press_acerto = eh_botao(cmd_atual) && (botoes == (4'b0001 << cmd_atual[1:0])) &&
                        (contador < CntJanela);
  // Include a press landing on the last beat cycle.
  assign pressionou   = pressionado_q || press;
  assign acertou      = pressionado_q ? acerto_q : press_acerto;

  always_comb begin
    estado_d      = estado_q;
    batidas_d     = batidas_q;
    cmd_d         = cmd_q;
    pressionado_d = pressionado_q;
    acerto_d      = acerto_q;
    trocar_d      = 1'b0;
    limpa         = 1'b0;
    conta_acerto  = 1'b0;
    conta_erro    = 1'b0;
    case (estado_q)
      StOcioso, StFim: begin
        if (iniciar) begin
          limpa         = 1'b1;
          trocar_d      = 1'b1;
          batidas_d     = '0;
          pressionado_d = 1'b0;
          estado_d      = StContagem;
        end
      end
      StContagem: begin
        if (fim_batida) begin
          if (batidas_q == LeadUlt) begin
            estado_d = StJogando;
          end else begin
            batidas_d = batidas_q + 1'b1;
          end
        end
      end
      StJogando: begin
        if (contador == CntAssent) begin
          cmd_d = prox_comando;
        end
        if ((contador == CntAssent) && fim_de_jogo) begin
          pressionado_d = 1'b0;
          estado_d      = StFim;
        end else begin
          if (press && !pressionado_q) begin
            pressionado_d = 1'b1;
            acerto_d      = press_acerto;
          end
          if (fim_batida) begin
            if (pressionou) begin
              conta_acerto = acertou;
              conta_erro   = !acertou;
            end else begin
              conta_erro = eh_botao(cmd_q);
            end
            pressionado_d = 1'b0;
            trocar_d      = 1'b1;
          end
        end
      end
      default: estado_d = StOcioso;
    endcase
  end

  always_comb begin
    acertos_d = acertos_q;
    erros_d   = erros_q;
    if (limpa) begin
      acertos_d = '0;
      erros_d   = '0;
    end else begin
      if (conta_acerto && (acertos_q != '1)) acertos_d = acertos_q + 1'b1;
      if (conta_erro && (erros_q != '1))     erros_d   = erros_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q      <= StOcioso;
      batidas_q     <= '0;
      botoes_q      <= '0;
      cmd_q         <= '0;
      pressionado_q <= 1'b0;
      acerto_q      <= 1'b0;
      trocar_q      <= 1'b0;
      acertos_q     <= '0;
      erros_q       <= '0;
    end else begin
      estado_q      <= estado_d;
      batidas_q     <= batidas_d;
      botoes_q      <= botoes;
      cmd_q         <= cmd_d;
      pressionado_q <= pressionado_d;
      acerto_q      <= acerto_d;
      trocar_q      <= trocar_d;
      acertos_q     <= acertos_d;
      erros_q       <= erros_d;
    end
  end

`ifdef CONTROLADOR_SEQUENCIA_EN
  logic [LARGURA_PONTOS-1:0] seq_q, seq_d, seq_max_q, seq_max_d;

  always_comb begin
    seq_d     = seq_q;
    seq_max_d = seq_max_q;
    if (limpa) begin
      seq_d     = '0;
      seq_max_d = '0;
    end else if (conta_acerto) begin
      if (seq_q != '1) seq_d = seq_q + 1'b1;
      if (seq_d > seq_max_q) seq_max_d = seq_d;
    end else if (conta_erro) begin
      seq_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q     <= '0;
      seq_max_q <= '0;
    end else begin
      seq_q     <= seq_d;
      seq_max_q <= seq_max_d;
    end
  end

  assign sequencia_max = seq_max_q;
`else
  assign sequencia_max = '0;
`endif

  assign trocar_comando   = trocar_q;
  assign batida           = ativo_q && inicio;
  assign acertos          = acertos_q;
  assign erros            = erros_q;
  assign jogando          = ativo_q;
  assign resultado_valido = (estado_q == StFim);

endmodule

// File: tb/tb_controlador_de_rodada.sv
module tb_controlador_de_rodada;

  localparam int C    = 10;
  localparam int J    = 6;
  localparam int B    = 2;
  localparam int W    = 10;
  localparam int MAXB = 1100;
  localparam int SAT  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         iniciar = 1'b0;
  logic [3:0]   botoes = 4'h0;
  logic [3:0]   prox_comando;
  logic         fim_de_jogo;
  logic         trocar_comando, batida, jogando, resultado_valido;
  logic [W-1:0] acertos, erros, sequencia_max;

  controlador_de_rodada #(
    .CICLOS_POR_BATIDA(C),
    .JANELA           (J),
    .BATIDAS_INICIAIS (B),
    .LARGURA_PONTOS   (W)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .iniciar         (iniciar),
    .botoes          (botoes),
    .prox_comando    (prox_comando),
    .fim_de_jogo     (fim_de_jogo),
    .trocar_comando  (trocar_comando),
    .batida          (batida),
    .acertos         (acertos),
    .erros           (erros),
    .jogando         (jogando),
    .resultado_valido(resultado_valido),
    .sequencia_max   (sequencia_max)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Beat plan: command plus up to two presses (cycle -1 means no press).
  logic [3:0] cmds [MAXB];
  int pc1 [MAXB];
  int pp1 [MAXB];
  int pc2 [MAXB];
  int pp2 [MAXB];
  int plen = 4;

  // Pattern manager model: first step after a start goes to index 0, later steps advance.
  int pm_idx = 0;
  bit pm_arm = 1'b0;
  always @(posedge clk) begin
    if (iniciar && !jogando) pm_arm <= 1'b1;
    if (trocar_comando) begin
      pm_idx <= pm_arm ? 0 : pm_idx + 1;
      pm_arm <= 1'b0;
    end
  end
  assign prox_comando = (pm_idx < plen) ? cmds[pm_idx] : 4'h0;
  assign fim_de_jogo  = (pm_idx >= plen);

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic verifica_zero(input string tag);
    verifica({tag, "_trocar"}, 32'(trocar_comando), 0);
    verifica({tag, "_batida"}, 32'(batida), 0);
    verifica({tag, "_acertos"}, 32'(acertos), 0);
    verifica({tag, "_erros"}, 32'(erros), 0);
    verifica({tag, "_jogando"}, 32'(jogando), 0);
    verifica({tag, "_valido"}, 32'(resultado_valido), 0);
    verifica({tag, "_seqmax"}, 32'(sequencia_max), 0);
  endtask

  // Scoring rule of one beat: 0 no change, 1 hit, 2 miss.
  function automatic int efeito(input int cmd, input int c1, input int p1, input int c2,
                                input int p2);
    int c = -1;
    int p = 0;
    if (c1 >= 2) begin
      c = c1; p = p1;
    end else if (c2 >= 2) begin
      c = c2; p = p2;
    end
    if (c < 0) return (cmd < 4) ? 2 : 0;
    if (cmd < 4 && p == (1 << cmd) && c < J) return 1;
    return 2;
  endfunction

  task automatic plano(input int b, input int cmd, input int c1, input int p1, input int c2,
                       input int p2);
    cmds[b] = 4'(cmd); pc1[b] = c1; pp1[b] = p1; pc2[b] = c2; pp2[b] = p2;
  endtask

  task automatic plano_aleatorio(input int b);
    int cmd, c1, p1, c2;
    case ($urandom_range(0, 5))
      0, 1, 2, 3: cmd = int'($urandom_range(0, 3));
      4:          cmd = 15;
      default:    cmd = int'($urandom_range(4, 14));
    endcase
    c1 = int'($urandom_range(0, 12));
    if (c1 > 9) c1 = -1;
    if (cmd < 4 && $urandom_range(0, 1) == 1) p1 = 1 << cmd;
    else p1 = int'($urandom_range(1, 15));
    c2 = -1;
    if (c1 >= 0 && c1 <= 7 && $urandom_range(0, 2) == 0) c2 = int'($urandom_range(c1 + 2, 9));
    plano(b, cmd, c1, p1, c2, int'($urandom_range(1, 15)));
  endtask

  task automatic rodada(input int n, input int aborta);
    int ea = 0, ee = 0, es = 0, em = 0, e, expmax;
    plen = n;
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
    for (int t = 0; t < C * B; t++) begin
      verifica("lead_trocar", 32'(trocar_comando), 32'(t == 0));
      verifica("lead_batida", 32'(batida), 32'(t % C == 0));
      verifica("lead_jogando", 32'(jogando), 1);
      if (t == 0) begin
        verifica("start_acertos", 32'(acertos), 0);
        verifica("start_erros", 32'(erros), 0);
        verifica("start_seqmax", 32'(sequencia_max), 0);
      end
      @(negedge clk);
    end
    for (int b = 0; b <= n; b++) begin
      for (int c = 0; c < C; c++) begin
`ifdef CONTROLADOR_SEQUENCIA_EN
        expmax = em;
`else
        expmax = 0;
`endif
        if (b == n && c == 3) begin
          verifica("fim_valido", 32'(resultado_valido), 1);
          verifica("fim_jogando", 32'(jogando), 0);
          verifica("fim_trocar", 32'(trocar_comando), 0);
          repeat (5) @(negedge clk);
          verifica("fim_valido_held", 32'(resultado_valido), 1);
          verifica("fim_batida", 32'(batida), 0);
          verifica("fim_acertos", 32'(acertos), 32'(ea));
          verifica("fim_erros", 32'(erros), 32'(ee));
          verifica("fim_seqmax", 32'(sequencia_max), 32'(expmax));
          return;
        end
        verifica("beat_trocar", 32'(trocar_comando), 32'(c == 0 && b > 0));
        verifica("beat_batida", 32'(batida), 32'(c == 0));
        if (c == 0) begin
          verifica("beat_acertos", 32'(acertos), 32'(ea));
          verifica("beat_erros", 32'(erros), 32'(ee));
          verifica("beat_seqmax", 32'(sequencia_max), 32'(expmax));
          verifica("beat_jogando", 32'(jogando), 1);
        end
        if (b == aborta && c == 5) begin
          reset_n = 1'b0;
          #1;
          verifica_zero("abort");
          @(negedge clk);
          botoes  = 4'h0;
          reset_n = 1'b1;
          return;
        end
        // A start request during play must have no effect.
        iniciar = (b == 1 && c == 5);
        if (b < n && c == pc1[b]) botoes = 4'(pp1[b]);
        else if (b < n && c == pc2[b]) botoes = 4'(pp2[b]);
        else botoes = 4'h0;
        if (b < n && c == C - 1) begin
          e = efeito(int'(cmds[b]), pc1[b], pp1[b], pc2[b], pp2[b]);
          if (e == 1) begin
            if (ea < SAT) ea++;
            if (es < SAT) es++;
            if (es > em) em = es;
          end else if (e == 2) begin
            if (ee < SAT) ee++;
            es = 0;
          end
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    verifica_zero("reset");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    verifica_zero("idle");

    // Hit, late miss, multi-bit miss, quiet rest beat.
    plano(0, 1, 4, 4'b0010, -1, 0);
    plano(1, 1, 7, 4'b0010, -1, 0);
    plano(2, 1, 3, 4'b0011, -1, 0);
    plano(3, 15, -1, 0, -1, 0);
    rodada(4, -1);

    // Press on rest, correct-then-wrong, window edge hit and miss, early press ignored.
    plano(0, 15, 5, 4'b0001, -1, 0);
    plano(1, 1, 3, 4'b0010, 4, 4'b1000);
    plano(2, 0, 5, 4'b0001, -1, 0);
    plano(3, 2, 6, 4'b0100, -1, 0);
    plano(4, 3, 1, 4'b1000, 3, 4'b1000);
    plano(5, 7, -1, 0, -1, 0);
    plano(6, 0, 9, 4'b0001, -1, 0);
    rodada(7, -1);

    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < 4; b++) plano_aleatorio(b);
      rodada(4, -1);
    end

    // Miss counter saturation.
    for (int b = 0; b < 1030; b++) plano(b, 1, -1, 0, -1, 0);
    rodada(1030, -1);

    plano(0, 2, 3, 4'b0100, -1, 0);
    for (int b = 1; b < 4; b++) plano_aleatorio(b);
    rodada(4, 1);
    repeat (2) @(negedge clk);
    verifica_zero("after_abort");

    for (int b = 0; b < 4; b++) plano_aleatorio(b);
    rodada(4, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/controlador_de_rodada.md
Name: controlador_de_rodada

Overview:
- Sequences one round of the rhythm game.
- Generates the beat timebase and drives the pattern manager's `trocar_comando` step pulse once per beat.
- Judges the player's button presses against the current command, counts hits (`acertos`) and misses (`erros`), and detects end of game.
- Sits between the pattern manager, the board buttons and the score display.

Parameters:
- CICLOS_POR_BATIDA, 25_000_000, clock cycles per beat (0.5 s at 50 MHz); must be ≥ 8.
- JANELA, 5_000_000, cycles from beat start within which a correct press counts as a hit; must be in 1..CICLOS_POR_BATIDA-1.
- BATIDAS_INICIAIS, 3, lead-in beats before judging starts; must be in 1..15.
- LARGURA_PONTOS, 10, width of the score counters.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, reset, asynchronous, active-low.
- iniciar, input, 1, start request; level sampled, acts on the first cycle seen high in OCIOSO or FIM.
- botoes, input, 4, player buttons, already synchronized, active-high.
- prox_comando, input, 4, current command from the pattern manager.
- fim_de_jogo, input, 1, end-of-pattern flag from the pattern manager.
- trocar_comando, output, 1, one-cycle step pulse to the pattern manager.
- batida, output, 1, one-cycle pulse at every beat start (visual/audio cue).
- acertos, output, LARGURA_PONTOS, hit count.
- erros, output, LARGURA_PONTOS, miss count.
- jogando, output, 1, high in CONTAGEM and JOGANDO.
- resultado_valido, output, 1, high in FIM.
- sequencia_max, output, LARGURA_PONTOS, longest hit streak (see Optional Feature).

Behaviour:
- Reset values: all outputs 0, FSM in OCIOSO, beat counter 0, edge-detect register 0.
- Command encoding:
  - 0..3 means button k expected.
  - 4'hF is PAUSA (no press expected).
  - 4..14 are reserved and treated as PAUSA.
- Beat timer:
  - Counter runs 0..CICLOS_POR_BATIDA-1 in CONTAGEM and JOGANDO, then wraps.
  - `batida` is high in the cycle the counter equals 0.
  - Counter is held at 0 in OCIOSO and FIM.
- FSM states: OCIOSO, CONTAGEM, JOGANDO, FIM.
- OCIOSO:
  - On `iniciar` high: clear acertos, erros and streak; pulse `trocar_comando` for one cycle; go to CONTAGEM.
  - This first pulse (re)initializes the pattern manager at index 0.
- CONTAGEM:
  - Counts BATIDAS_INICIAIS beats; no judging; no `trocar_comando`.
  - After the last lead-in beat's final cycle, go to JOGANDO with counter 0.
- JOGANDO:
  - Capture the expected command at counter == 2, so the pattern manager output has settled after the pulse.
  - Press detection: rising edge on any `botoes` bit while counter ≥ 2.
  - Only the first press of a beat is judged; later presses are ignored.
  - First press is the single bit equal to the expected button, and counter < JANELA: hit.
  - Any other first press (wrong button, more than one bit set, late, or press during PAUSA): miss.
  - Beat-end judgement at counter == CICLOS_POR_BATIDA-1:
    - button expected and no press: miss;
    - PAUSA and no press: no change.
  - Exactly one score update per beat, committed at beat end.
  - `trocar_comando` is pulsed the cycle after beat end, i.e. the same cycle counter returns to 0.
- End detection:
  - At counter == 2, if `fim_de_jogo` == 1, discard the current beat (no judgement) and go to FIM.
- FIM:
  - Scores held; `resultado_valido` = 1.
  - `iniciar` behaves as in OCIOSO (clears scores, pulses, goes to CONTAGEM).
- Counters `acertos` and `erros` saturate at all-ones.
- Simultaneous edge and beat end: the press at counter == CICLOS_POR_BATIDA-1 is judged in that beat before the end check.
- `iniciar` is ignored in CONTAGEM and JOGANDO.
- Reset mid-round: all outputs return to reset values immediately.
  - The pattern manager has no reset and is not re-synchronized.
  - Known system limitation: the pattern manager must be restarted by the top-level after power-up.

Optional Feature:
- Macro CONTROLADOR_SEQUENCIA_EN.
- Defined:
  - Internal streak counter increments on each hit and clears on each miss; it is not cleared by PAUSA beats with no press.
  - `sequencia_max` is updated to the streak whenever the streak exceeds it; saturating.
  - Cleared on `iniciar`.
- Undefined: `sequencia_max` is tied to 0 and no streak logic is synthesized.

Decomposition:
- Shared package holds:
  - the FSM state enum;
  - CMD_PAUSA = 4'hF;
  - NUM_BOTOES = 4;
  - the settle offset constant (2).
- One natural sub-module: temporizador_de_batida.
  - Parameterised beat counter with enable.
  - Outputs the counter value, an `inicio` pulse and a `fim` pulse.

Test Plan (CICLOS_POR_BATIDA=10, JANELA=6, BATIDAS_INICIAIS=2, pattern model ends after 4 commands):
- Reset, then `iniciar` high 1 cycle:
  - exactly 1 `trocar_comando` pulse, `jogando`=1;
  - no further pulse for 20 cycles;
  - then one pulse every 10 cycles.
- Command 1, botoes=4'b0010 edge at counter 4 → acertos=1, erros=0 at beat end.
- Command 1:
  - edge at counter 7 → erros=1 (late);
  - repeat with 4'b0011 at counter 3 → erros=2.
- Command 4'hF:
  - no press → no change;
  - press 4'b0001 at counter 5 → erros+1.
- Two edges in one beat, first correct at counter 3, second wrong at counter 4 → acertos+1 only.
- fim_de_jogo=1 seen at counter 2:
  - FIM, resultado_valido=1, scores held;
  - reset_n low mid-JOGANDO → all outputs 0 asynchronously.
